// File: rtl/button_debounce_fsm_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_fsm_pkg
// Shared definitions for the push-button debouncer:
//   - state_t             : 2-bit binary FSM encoding
//   - SYNC_STAGES_DEFAULT : default synchronizer depth
//   - is_high_state()     : true for the states in which the debounced level is 1
// -----------------------------------------------------------------------------
package button_debounce_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;

    // The debounced level stays high until a release has been confirmed,
    // so WAIT_LOW still counts as "high".
    function automatic logic is_high_state(input state_t s);
        return (s == IDLE_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/button_debounce_fsm_sync.sv
// -----------------------------------------------------------------------------
// input_synchronizer
// Multi-flop synchronizer for a single asynchronous level.
// Ports:
//   i_clock  - clock
//   i_reset  - synchronous active-high reset, clears every stage
//   i_async  - asynchronous input level
//   o_sync   - output of the final stage
// Parameter SyncStages: number of flops in the chain, legal range 2..4.
// -----------------------------------------------------------------------------
module input_synchronizer #(
    parameter int SyncStages = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SyncStages-1:0] r_sync;

    // Shift chain: new sample enters at bit 0, leaves from the top bit.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync <= {SyncStages{1'b0}};
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SyncStages-1];

endmodule

// File: rtl/button_debounce_fsm.sv
// -----------------------------------------------------------------------------
// button_debounce_fsm
// Moore debouncer for a bouncing push button. A press or release is accepted
// only once the synchronized level has stayed put until an external delay
// timer expires; the timer lives next to this block and is controlled by
// o_start.
// Ports:
//   i_clock       - clock, all state changes on the rising edge
//   i_reset       - synchronous active-high reset, highest priority
//   i_button_in   - raw asynchronous button level
//   i_timeout     - one-cycle expiry strobe from the companion timer
//   o_start       - timer control: 1 holds the timer cleared, 0 lets it count
//   o_debounced   - registered debounced level
//   o_rise_pulse  - registered one-cycle strobe on an accepted press
//   o_fall_pulse  - registered one-cycle strobe on an accepted release
//   o_press_count - accepted press count, wraps silently
// -----------------------------------------------------------------------------
module button_debounce_fsm
    import button_debounce_fsm_pkg::*;
#(
    parameter int SyncStages = SYNC_STAGES_DEFAULT,
    parameter int CountBits  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_button_in,
    input  logic                 i_timeout,
    output logic                 o_start,
    output logic                 o_debounced,
    output logic                 o_rise_pulse,
    output logic                 o_fall_pulse,
    output logic [CountBits-1:0] o_press_count
);

    logic   w_btn_sync;
    state_t r_state;
    state_t w_next_state;

    input_synchronizer #(
        .SyncStages (SyncStages)
    ) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_button_in),
        .o_sync  (w_btn_sync)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE_LOW;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. In the wait states the level check comes before the
    // timeout so that a reversal coinciding with expiry aborts the wait.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE_LOW: begin
                if (w_btn_sync) w_next_state = WAIT_HIGH;
                else            w_next_state = IDLE_LOW;
            end
            WAIT_HIGH: begin
                if (!w_btn_sync)    w_next_state = IDLE_LOW;
                else if (i_timeout) w_next_state = IDLE_HIGH;
                else                w_next_state = WAIT_HIGH;
            end
            IDLE_HIGH: begin
                if (!w_btn_sync) w_next_state = WAIT_LOW;
                else             w_next_state = IDLE_HIGH;
            end
            WAIT_LOW: begin
                if (w_btn_sync)     w_next_state = IDLE_HIGH;
                else if (i_timeout) w_next_state = IDLE_LOW;
                else                w_next_state = WAIT_LOW;
            end
            default: begin
                w_next_state = IDLE_LOW;
            end
        endcase
    end

    // Timer is held cleared whenever no wait is in progress.
    assign o_start = (r_state == IDLE_LOW) || (r_state == IDLE_HIGH);

    // Outputs are registered from the next state so they line up with the
    // state register rather than lagging it by a cycle. Pulses fire only on
    // a completed wait, never on an aborted one.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_debounced   <= 1'b0;
            o_rise_pulse  <= 1'b0;
            o_fall_pulse  <= 1'b0;
            o_press_count <= {CountBits{1'b0}};
        end else begin
            o_debounced  <= is_high_state(w_next_state);
            o_rise_pulse <= (r_state == WAIT_HIGH) && (w_next_state == IDLE_HIGH);
            o_fall_pulse <= (r_state == WAIT_LOW)  && (w_next_state == IDLE_LOW);
            if ((r_state == WAIT_HIGH) && (w_next_state == IDLE_HIGH)) begin
                o_press_count <= o_press_count + {{(CountBits-1){1'b0}}, 1'b1};
            end else begin
                o_press_count <= o_press_count;
            end
        end
    end

endmodule

// File: tb/tb_button_debounce_fsm.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_fsm
// Bench for button_debounce_fsm with SyncStages=2, CountBits=8 and a
// companion delay timer with MaxCount=3 modelled here. Per-cycle vectors
// cover reset, press, release, bounce, timeout in idle, simultaneous
// reversal/timeout and reset mid-wait; a loop then checks counter wrap.
// -----------------------------------------------------------------------------
module tb_button_debounce_fsm;

    localparam logic [1:0] MAX_COUNT = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       force_to;
    logic       timeout;
    logic       start;
    logic       deb;
    logic       rise;
    logic       fall;
    logic [7:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int rise_total = 0;
    int overlap    = 0;

    always #5 clk = ~clk;

    button_debounce_fsm #(
        .SyncStages (2),
        .CountBits  (8)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_button_in   (btn),
        .i_timeout     (timeout),
        .o_start       (start),
        .o_debounced   (deb),
        .o_rise_pulse  (rise),
        .o_fall_pulse  (fall),
        .o_press_count (cnt)
    );

    // Companion delay timer: cleared while start=1, strobes at MAX_COUNT.
    logic [1:0] tcnt = 2'd0;
    always @(posedge clk) begin
        if (rst || start)           tcnt <= 2'd0;
        else if (tcnt == MAX_COUNT) tcnt <= 2'd0;
        else                        tcnt <= tcnt + 2'd1;
    end
    assign timeout = (tcnt == MAX_COUNT) | force_to;

    // Pulse monitors.
    always @(posedge clk) begin
        if (rise)         rise_total <= rise_total + 1;
        if (rise && fall) overlap    <= overlap + 1;
    end

    typedef struct {
        logic       btn;
        logic       force_to;
        logic       rst;
        logic       start;
        logic       deb;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic b, input logic f, input logic r,
                       input logic s, input logic d, input logic ri,
                       input logic fa, input logic [7:0] c);
        vec_t v;
        v.btn = b; v.force_to = f; v.rst = r;
        v.start = s; v.deb = d; v.rise = ri; v.fall = fa; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // One full press and release, each bounded by a cycle budget.
    task automatic press_release(input int idx);
        bit done;
        btn = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (deb) done = 1'b1;
        end
        if (!done) chk("press_timeout", idx, 32'd0, 32'd1);
        btn = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!deb) done = 1'b1;
        end
        if (!done) chk("release_timeout", idx, 32'd0, 32'd1);
    endtask

    int rise_base;

    initial begin
        rst = 1'b1; btn = 1'b0; force_to = 1'b0;

        // btn force rst | start deb rise fall cnt
        // reset
        add(0,0,1, 1,0,0,0,8'd0);
        add(0,0,1, 1,0,0,0,8'd0);
        // clean press: WAIT_HIGH after edge 3, accepted after edge 7
        add(1,0,0, 1,0,0,0,8'd0);
        add(1,0,0, 1,0,0,0,8'd0);
        add(1,0,0, 0,0,0,0,8'd0);
        add(1,0,0, 0,0,0,0,8'd0);
        add(1,0,0, 0,0,0,0,8'd0);
        add(1,0,0, 0,0,0,0,8'd0);
        add(1,0,0, 1,1,1,0,8'd1);
        add(1,0,0, 1,1,0,0,8'd1);
        // timeout ignored in IDLE_HIGH
        add(1,1,0, 1,1,0,0,8'd1);
        add(1,0,0, 1,1,0,0,8'd1);
        // clean release
        add(0,0,0, 1,1,0,0,8'd1);
        add(0,0,0, 1,1,0,0,8'd1);
        add(0,0,0, 0,1,0,0,8'd1);
        add(0,0,0, 0,1,0,0,8'd1);
        add(0,0,0, 0,1,0,0,8'd1);
        add(0,0,0, 0,1,0,0,8'd1);
        add(0,0,0, 1,0,0,1,8'd1);
        add(0,0,0, 1,0,0,0,8'd1);
        // timeout ignored in IDLE_LOW
        add(0,1,0, 1,0,0,0,8'd1);
        add(0,0,0, 1,0,0,0,8'd1);
        // bounce: high two cycles, wait aborts
        add(1,0,0, 1,0,0,0,8'd1);
        add(1,0,0, 1,0,0,0,8'd1);
        add(0,0,0, 0,0,0,0,8'd1);
        add(0,0,0, 0,0,0,0,8'd1);
        add(0,0,0, 1,0,0,0,8'd1);
        add(0,0,0, 1,0,0,0,8'd1);
        // reversal in the same cycle as timeout: reversal wins
        add(1,0,0, 1,0,0,0,8'd1);
        add(1,0,0, 1,0,0,0,8'd1);
        add(1,0,0, 0,0,0,0,8'd1);
        add(1,0,0, 0,0,0,0,8'd1);
        add(0,0,0, 0,0,0,0,8'd1);
        add(0,0,0, 0,0,0,0,8'd1);
        add(0,0,0, 1,0,0,0,8'd1);
        add(0,0,0, 1,0,0,0,8'd1);
        // reset in WAIT_HIGH
        add(1,0,0, 1,0,0,0,8'd1);
        add(1,0,0, 1,0,0,0,8'd1);
        add(1,0,0, 0,0,0,0,8'd1);
        add(1,0,1, 1,0,0,0,8'd0);
        add(0,0,0, 1,0,0,0,8'd0);
        add(0,0,0, 1,0,0,0,8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            btn      = vecs[i].btn;
            force_to = vecs[i].force_to;
            rst      = vecs[i].rst;
            @(posedge clk);
            #1;
            chk("start",       i, {31'd0, start}, {31'd0, vecs[i].start});
            chk("debounced",   i, {31'd0, deb},   {31'd0, vecs[i].deb});
            chk("rise_pulse",  i, {31'd0, rise},  {31'd0, vecs[i].rise});
            chk("fall_pulse",  i, {31'd0, fall},  {31'd0, vecs[i].fall});
            chk("press_count", i, {24'd0, cnt},   {24'd0, vecs[i].cnt});
        end

        // Counter wrap: 256 clean presses starting from 0.
        @(negedge clk);
        force_to = 1'b0;
        rise_base = rise_total;
        for (int p = 0; p < 255; p++) press_release(p);
        repeat (2) @(negedge clk);
        chk("count_at_255", 255, {24'd0, cnt}, 32'd255);
        press_release(255);
        repeat (2) @(negedge clk);
        chk("count_wrap", 256, {24'd0, cnt}, 32'd0);
        chk("rise_strobes", 256, rise_total - rise_base, 32'd256);
        chk("rise_fall_overlap", 256, overlap, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
